sb_rx_deframer: RTL

Sideband receive deframer for the USB4 logical layer. It sits directly downstream of the `sbrx` pin and upstream of the logical layer's link-training and adapter-transaction handlers. It recovers UART-style symbols from `sbrx`, strips DLE/STX … DLE/ETX framing and DLE stuffing, and presents each complete transaction as a parallel payload through a valid/ready handshake, together with its type and byte length. Malformed traffic raises an error pulse and the block returns to frame hunting.

---
 rtl/sb_rx_deframer.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sb_rx_deframer.sv
// Sideband receive deframer.
// Recovers 10-bit UART symbols (start, 8 data bits LSB first, stop) from
// sbrx, strips DLE/STX ... DLE/ETX framing and DLE stuffing, and hands each
// complete transaction to the consumer over a valid/ready handshake.
// Three register stages line up every outcome of a byte at the same point:
//   edge E   : stop bit sampled, byte (or stop error) registered
//   edge E+1 : framer consumes the byte, raises a completion or error request
//   edge E+2 : output registers load / frame_err pulses
module sb_rx_deframer #(
    parameter int MAX_BYTES = 16,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   sb_clk,
    input  logic                   rst,
    input  logic                   sbrx,
    input  logic                   rx_enable,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic [1:0]             frame_type,
    output logic [LEN_W-1:0]       frame_len,
    output logic [8*MAX_BYTES-1:0] frame_data,
    output logic                   frame_err,
    output logic [2:0]             err_code
);

    // Framing control characters
    localparam logic [7:0] DLE     = 8'hFE;
    localparam logic [7:0] ETX     = 8'h40;
    localparam logic [7:0] STX_LT  = 8'h20;
    localparam logic [7:0] STX_ATC = 8'h05;
    localparam logic [7:0] STX_ATR = 8'h04;

    // Frame type encodings presented on frame_type
    localparam logic [1:0] TYPE_LT  = 2'd0;
    localparam logic [1:0] TYPE_ATC = 2'd1;
    localparam logic [1:0] TYPE_ATR = 2'd2;

    // Error cause encodings presented on err_code
    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_STOP    = 3'd1;
    localparam logic [2:0] ERR_OVFL    = 3'd2;
    localparam logic [2:0] ERR_ESC     = 3'd3;
    localparam logic [2:0] ERR_EMPTY   = 3'd4;
    localparam logic [2:0] ERR_OVERRUN = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_STOP = 2'd2
    } sym_state_t;

    typedef enum logic [1:0] {
        F_HUNT  = 2'd0,
        F_DLE_H = 2'd1,
        F_PAY   = 2'd2,
        F_DLE_P = 2'd3
    } frm_state_t;

    // True for any of the three start-of-transaction characters
    function automatic logic is_stx(input logic [7:0] b);
        is_stx = (b == STX_LT) || (b == STX_ATC) || (b == STX_ATR);
    endfunction

    // Maps a start-of-transaction character to its frame type
    function automatic logic [1:0] stx_to_type(input logic [7:0] b);
        case (b)
            STX_LT:  stx_to_type = TYPE_LT;
            STX_ATC: stx_to_type = TYPE_ATC;
            STX_ATR: stx_to_type = TYPE_ATR;
            default: stx_to_type = TYPE_LT;
        endcase
    endfunction

    // Symbol receiver state
    sym_state_t r_sym_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_byte;
    logic       r_byte_vld;
    logic       r_stop_err;

    // Framer state and assembly buffer
    frm_state_t             r_frm_state;
    logic [LEN_W-1:0]       r_count;
    logic [8*MAX_BYTES-1:0] r_buf;
    logic [1:0]             r_type;
    logic                   r_cmp_pend;
    logic                   r_err_pend;
    logic [2:0]             r_err_pend_code;

    // Byte classification for the framer
    logic w_is_dle;
    logic w_is_etx;
    logic w_is_stx;
    logic w_buf_full;
    logic w_buf_empty;

    // Classify the received byte and the fill level of the assembly buffer
    always_comb begin
        w_is_dle    = (r_byte == DLE);
        w_is_etx    = (r_byte == ETX);
        w_is_stx    = is_stx(r_byte);
        w_buf_full  = (r_count == LEN_W'(MAX_BYTES));
        w_buf_empty = (r_count == {LEN_W{1'b0}});
    end

    // Symbol receiver: start-bit detect, 8 data bits LSB first, stop-bit check
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            r_sym_state <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_byte      <= 8'h00;
            r_byte_vld  <= 1'b0;
            r_stop_err  <= 1'b0;
        end else if (!rx_enable) begin
            r_sym_state <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_byte_vld  <= 1'b0;
            r_stop_err  <= 1'b0;
        end else begin
            r_byte_vld <= 1'b0;
            r_stop_err <= 1'b0;
            case (r_sym_state)
                S_IDLE: begin
                    if (!sbrx) begin
                        r_sym_state <= S_DATA;
                        r_bit_cnt   <= 3'd0;
                    end
                end
                S_DATA: begin
                    r_shift   <= {sbrx, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_sym_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (sbrx) begin
                        r_byte_vld <= 1'b1;
                        r_byte     <= r_shift;
                    end else begin
                        r_stop_err <= 1'b1;
                    end
                    // Back to idle at once so a start bit on the next cycle is caught
                    r_sym_state <= S_IDLE;
                end
                default: begin
                    r_sym_state <= S_IDLE;
                end
            endcase
        end
    end

    // Framer: hunt for DLE/STX, collect unstuffed payload, detect DLE/ETX and errors
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            r_frm_state     <= F_HUNT;
            r_count         <= '0;
            r_buf           <= '0;
            r_type          <= TYPE_LT;
            r_cmp_pend      <= 1'b0;
            r_err_pend      <= 1'b0;
            r_err_pend_code <= ERR_NONE;
        end else begin
            r_cmp_pend <= 1'b0;
            r_err_pend <= 1'b0;
            if (!rx_enable) begin
                // Partial frame silently discarded; a held output frame is untouched
                r_frm_state <= F_HUNT;
            end else if (r_stop_err) begin
                r_frm_state     <= F_HUNT;
                r_err_pend      <= 1'b1;
                r_err_pend_code <= ERR_STOP;
            end else if (r_byte_vld) begin
                case (r_frm_state)
                    F_HUNT: begin
                        if (w_is_dle) begin
                            r_frm_state <= F_DLE_H;
                        end
                    end
                    F_DLE_H: begin
                        if (w_is_stx) begin
                            r_frm_state <= F_PAY;
                            r_type      <= stx_to_type(r_byte);
                            r_count     <= '0;
                            r_buf       <= '0;
                        end else if (!w_is_dle) begin
                            r_frm_state <= F_HUNT;
                        end
                    end
                    F_PAY, F_DLE_P: begin
                        if ((r_frm_state == F_PAY) && w_is_dle) begin
                            r_frm_state <= F_DLE_P;
                        end else if ((r_frm_state == F_DLE_P) && w_is_etx) begin
                            r_frm_state <= F_HUNT;
                            if (w_buf_empty) begin
                                r_err_pend      <= 1'b1;
                                r_err_pend_code <= ERR_EMPTY;
                            end else begin
                                r_cmp_pend <= 1'b1;
                            end
                        end else if ((r_frm_state == F_DLE_P) && !w_is_dle) begin
                            r_frm_state     <= F_HUNT;
                            r_err_pend      <= 1'b1;
                            r_err_pend_code <= ERR_ESC;
                        end else if (w_buf_full) begin
                            // Plain data in F_PAY or a stuffed DLE with no room left
                            r_frm_state     <= F_HUNT;
                            r_err_pend      <= 1'b1;
                            r_err_pend_code <= ERR_OVFL;
                        end else begin
                            // A stuffed DLE stores 0xFE, which is exactly r_byte
                            for (int i = 0; i < MAX_BYTES; i++) begin
                                if (r_count == LEN_W'(i)) begin
                                    r_buf[i*8 +: 8] <= r_byte;
                                end
                            end
                            r_count     <= r_count + LEN_W'(1);
                            r_frm_state <= F_PAY;
                        end
                    end
                    default: begin
                        r_frm_state <= F_HUNT;
                    end
                endcase
            end
        end
    end

    // Output stage: present completed frames, detect overrun, pulse errors
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            frame_valid <= 1'b0;
            frame_type  <= TYPE_LT;
            frame_len   <= '0;
            frame_data  <= '0;
            frame_err   <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            frame_err <= 1'b0;
            if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
            if (r_cmp_pend) begin
                if (!frame_valid || frame_ready) begin
                    frame_valid <= 1'b1;
                    frame_type  <= r_type;
                    frame_len   <= r_count;
                    frame_data  <= r_buf;
                end else begin
                    // Consumer still holds the previous frame: drop the new one
                    frame_err <= 1'b1;
                    err_code  <= ERR_OVERRUN;
                end
            end else if (r_err_pend) begin
                frame_err <= 1'b1;
                err_code  <= r_err_pend_code;
            end
        end
    end

endmodule
